ahb3lite_interconnect_slave_port: RTL and testbench

AHB3LITE_INTERCONNECT_SLAVE_PORT -- requirements
Module: ahb3lite_interconnect_slave_port

---
 rtl/ahb3lite_pkg.sv | 21 ++
 rtl/ahb3lite_interconnect_slave_port_if.sv | 59 +++++
 rtl/ahb3lite_interconnect_slave_arb.sv | 58 +++++
 rtl/ahb3lite_interconnect_slave_port.sv | 96 +++++++++
 tb/tb_ahb3lite_interconnect_slave_port.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb3lite_pkg.sv
// rtl/ahb3lite_pkg.sv - AHB3-Lite protocol constants shared by the interconnect blocks
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb3lite_interconnect_slave_port_if.sv
// rtl/ahb3lite_interconnect_slave_port_if.sv - bus bundle between master ports, the slave port and the AHB slave
interface ahb3lite_interconnect_slave_port_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int MASTERS    = 3
);
    logic [MASTERS-1:0][2:0]            mstpriority;
    logic [MASTERS-1:0]                 mstHSEL;
    logic [MASTERS-1:0][HADDR_SIZE-1:0] mstHADDR;
    logic [MASTERS-1:0][HDATA_SIZE-1:0] mstHWDATA;
    logic [MASTERS-1:0]                 mstHWRITE;
    logic [MASTERS-1:0][2:0]            mstHSIZE;
    logic [MASTERS-1:0][2:0]            mstHBURST;
    logic [MASTERS-1:0][3:0]            mstHPROT;
    logic [MASTERS-1:0][1:0]            mstHTRANS;
    logic [MASTERS-1:0]                 mstHMASTLOCK;
    logic [MASTERS-1:0]                 mstHREADY;
    logic [MASTERS-1:0]                 can_switch;
    logic [MASTERS-1:0]                 master_granted;

    logic [HDATA_SIZE-1:0]              mstHRDATA;
    logic                               mstHREADYOUT;
    logic                               mstHRESP;

    logic                               slv_HSEL;
    logic [HADDR_SIZE-1:0]              slv_HADDR;
    logic [HDATA_SIZE-1:0]              slv_HWDATA;
    logic                               slv_HWRITE;
    logic [2:0]                         slv_HSIZE;
    logic [2:0]                         slv_HBURST;
    logic [3:0]                         slv_HPROT;
    logic [1:0]                         slv_HTRANS;
    logic                               slv_HMASTLOCK;
    logic                               slv_HREADYOUT;
    logic [HDATA_SIZE-1:0]              slv_HRDATA;
    logic                               slv_HREADY;
    logic                               slv_HRESP;

    // slave: the interconnect slave port itself
    modport slave (
        input  mstpriority, mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHSIZE,
               mstHBURST, mstHPROT, mstHTRANS, mstHMASTLOCK, mstHREADY, can_switch,
               slv_HRDATA, slv_HREADY, slv_HRESP,
        output master_granted, mstHRDATA, mstHREADYOUT, mstHRESP,
               slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE, slv_HBURST,
               slv_HPROT, slv_HTRANS, slv_HMASTLOCK, slv_HREADYOUT
    );

    // master: the surrounding fabric (master ports and the AHB slave)
    modport master (
        output mstpriority, mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHSIZE,
               mstHBURST, mstHPROT, mstHTRANS, mstHMASTLOCK, mstHREADY, can_switch,
               slv_HRDATA, slv_HREADY, slv_HRESP,
        input  master_granted, mstHRDATA, mstHREADYOUT, mstHRESP,
               slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE, slv_HBURST,
               slv_HPROT, slv_HTRANS, slv_HMASTLOCK, slv_HREADYOUT
    );

endinterface

// File: rtl/ahb3lite_interconnect_slave_arb.sv
// rtl/ahb3lite_interconnect_slave_arb.sv - priority arbiter with round-robin tie break and grant register
module ahb3lite_interconnect_slave_arb #(
    parameter int MASTERS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [MASTERS-1:0]      req,
    input  logic [MASTERS-1:0][2:0] prio,
    input  logic                    update,
    output logic [MASTERS-1:0]      granted
);

    generate
        if (MASTERS == 1) begin : g_single
            assign granted = 1'b1;
        end else begin : g_multi
            localparam int IW = $clog2(MASTERS);

            logic [IW-1:0]      ptr;
            logic [IW-1:0]      idx;
            logic [IW-1:0]      win_idx;
            logic               win_valid;
            logic [2:0]         best;
            logic [MASTERS-1:0] grant_q;

            // Scan starting just after the last winner; strict '>' keeps the
            // earliest candidate in rotation order on a priority tie.
            always_comb begin
                idx       = '0;
                win_idx   = ptr;
                win_valid = 1'b0;
                best      = '0;
                for (int k = 1; k <= MASTERS; k++) begin
                    idx = IW'((int'(ptr) + k) % MASTERS);
                    if (req[idx] && (!win_valid || prio[idx] > best)) begin
                        win_valid = 1'b1;
                        best      = prio[idx];
                        win_idx   = idx;
                    end
                end
            end

            // Pointer resets to the last index so master 0 wins the first tie.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    grant_q <= MASTERS'(1);
                    ptr     <= IW'(MASTERS - 1);
                end else if (update && win_valid) begin
                    grant_q <= MASTERS'(1) << win_idx;
                    ptr     <= win_idx;
                end
            end

            assign granted = grant_q;
        end
    endgenerate

endmodule

// File: rtl/ahb3lite_interconnect_slave_port.sv
// rtl/ahb3lite_interconnect_slave_port.sv - AHB3-Lite interconnect slave port: arbitrates master ports onto one slave
module ahb3lite_interconnect_slave_port
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int MASTERS    = 3
) (
    input logic                             HCLK,
    input logic                             HRESETn,
    ahb3lite_interconnect_slave_port_if.slave bus
);

    logic [MASTERS-1:0]    granted;
    logic [MASTERS-1:0]    data_owner;
    logic                  owner_sel;
    logic                  owner_lock;
    logic                  owner_cs;
    logic                  owner_ready;
    logic                  owner_write;
    logic [HADDR_SIZE-1:0] owner_addr;
    logic [HDATA_SIZE-1:0] data_wdata;
    logic [2:0]            owner_size;
    logic [2:0]            owner_burst;
    logic [3:0]            owner_prot;
    logic [1:0]            owner_trans;
    logic                  update;

    // One-hot AND-OR muxes; with a single master these collapse to wires.
    always_comb begin
        owner_sel   = 1'b0;
        owner_lock  = 1'b0;
        owner_cs    = 1'b0;
        owner_ready = 1'b0;
        owner_write = 1'b0;
        owner_addr  = '0;
        owner_size  = '0;
        owner_burst = '0;
        owner_prot  = '0;
        owner_trans = '0;
        data_wdata  = '0;
        for (int i = 0; i < MASTERS; i++) begin
            owner_sel   = owner_sel   | (bus.mstHSEL[i]      & granted[i]);
            owner_lock  = owner_lock  | (bus.mstHMASTLOCK[i] & granted[i]);
            owner_cs    = owner_cs    | (bus.can_switch[i]   & granted[i]);
            owner_ready = owner_ready | (bus.mstHREADY[i]    & granted[i]);
            owner_write = owner_write | (bus.mstHWRITE[i]    & granted[i]);
            owner_addr  = owner_addr  | (bus.mstHADDR[i]  & {HADDR_SIZE{granted[i]}});
            owner_size  = owner_size  | (bus.mstHSIZE[i]  & {3{granted[i]}});
            owner_burst = owner_burst | (bus.mstHBURST[i] & {3{granted[i]}});
            owner_prot  = owner_prot  | (bus.mstHPROT[i]  & {4{granted[i]}});
            owner_trans = owner_trans | (bus.mstHTRANS[i] & {2{granted[i]}});
            data_wdata  = data_wdata  | (bus.mstHWDATA[i] & {HDATA_SIZE{data_owner[i]}});
        end
    end

    // Hand-over only at a transfer boundary the owner allows and never inside a locked sequence.
    assign update = bus.slv_HREADY & (owner_cs | ~owner_sel) & ~owner_lock;

    ahb3lite_interconnect_slave_arb #(
        .MASTERS (MASTERS)
    ) u_arb (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .req     (bus.mstHSEL),
        .prio    (bus.mstpriority),
        .update  (update),
        .granted (granted)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_owner <= MASTERS'(1);
        end else if (bus.slv_HREADY) begin
            data_owner <= granted;
        end
    end

    assign bus.master_granted = granted;

    assign bus.slv_HSEL      = owner_sel;
    assign bus.slv_HADDR     = owner_addr;
    assign bus.slv_HWRITE    = owner_write;
    assign bus.slv_HSIZE     = owner_size;
    assign bus.slv_HBURST    = owner_burst;
    assign bus.slv_HPROT     = owner_prot;
    assign bus.slv_HMASTLOCK = owner_lock;
    assign bus.slv_HTRANS    = owner_sel ? owner_trans : HTRANS_IDLE;
    assign bus.slv_HWDATA    = data_wdata;
    assign bus.slv_HREADYOUT = owner_ready;

    assign bus.mstHRDATA    = bus.slv_HRDATA;
    assign bus.mstHREADYOUT = bus.slv_HREADY;
    assign bus.mstHRESP     = bus.slv_HRESP;

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_port.sv
// tb/tb_ahb3lite_interconnect_slave_port.sv - self-checking bench for the interconnect slave port
module tb_ahb3lite_interconnect_slave_port;
    import ahb3lite_pkg::*;

    localparam int M  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb3lite_interconnect_slave_port_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .MASTERS(M)) bus ();

    ahb3lite_interconnect_slave_port #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .MASTERS(M)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: owner index, last-granted index, data-phase owner index.
    int m_owner;
    int m_last;
    int m_downer;

    function automatic int pick_winner();
        int best = -1;
        int w = -1;
        for (int i = 0; i < M; i++)
            if (bus.mstHSEL[i] && int'(bus.mstpriority[i]) > best) best = int'(bus.mstpriority[i]);
        for (int k = 1; k <= M; k++) begin
            int j = (m_last + k) % M;
            if (w < 0 && bus.mstHSEL[j] && int'(bus.mstpriority[j]) == best) w = j;
        end
        return w;
    endfunction

    task automatic model_step();
        int w = pick_winner();
        bit may = bus.slv_HREADY && (bus.can_switch[m_owner] || !bus.mstHSEL[m_owner]) && !bus.mstHMASTLOCK[m_owner];
        if (bus.slv_HREADY) m_downer = m_owner;
        if (may && w >= 0) begin
            m_owner = w;
            m_last  = w;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_idle();
        for (int i = 0; i < M; i++) begin
            bus.mstpriority[i]  = 3'd0;
            bus.mstHSEL[i]      = 1'b0;
            bus.mstHADDR[i]     = $urandom;
            bus.mstHWDATA[i]    = $urandom;
            bus.mstHWRITE[i]    = 1'b0;
            bus.mstHSIZE[i]     = 3'b010;
            bus.mstHBURST[i]    = HBURST_SINGLE;
            bus.mstHPROT[i]     = 4'b0011;
            bus.mstHTRANS[i]    = HTRANS_IDLE;
            bus.mstHMASTLOCK[i] = 1'b0;
            bus.mstHREADY[i]    = 1'b1;
            bus.can_switch[i]   = 1'b1;
        end
        bus.slv_HRDATA = $urandom;
        bus.slv_HREADY = 1'b1;
        bus.slv_HRESP  = HRESP_OKAY;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        set_idle();
        m_owner  = 0;
        m_last   = M - 1;
        m_downer = 0;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.master_granted !== 3'b001) begin
            errors++;
            $display("FAIL reset_grant: got %b want %b", bus.master_granted, 3'b001);
        end
        vectors++;
        if (bus.slv_HADDR !== bus.mstHADDR[0]) begin
            errors++;
            $display("FAIL reset_haddr: got %h want %h", bus.slv_HADDR, bus.mstHADDR[0]);
        end
        vectors++;
        if (bus.slv_HWDATA !== bus.mstHWDATA[0]) begin
            errors++;
            $display("FAIL reset_hwdata: got %h want %h", bus.slv_HWDATA, bus.mstHWDATA[0]);
        end
        vectors++;
        if (bus.slv_HTRANS !== HTRANS_IDLE || bus.slv_HSEL !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got htrans %b hsel %b want 00 0", bus.slv_HTRANS, bus.slv_HSEL);
        end
    endtask

    task automatic test_single_request();
        do_reset();
        bus.mstHSEL[1]     = 1'b1;
        bus.mstHTRANS[1]   = HTRANS_NONSEQ;
        bus.mstpriority[1] = 3'd2;
        bus.can_switch[0]  = 1'b1;
        #1;
        vectors++;
        if (bus.master_granted !== 3'b001) begin
            errors++;
            $display("FAIL single_before: got %b want %b", bus.master_granted, 3'b001);
        end
        tick();
        vectors++;
        if (bus.master_granted !== 3'b010) begin
            errors++;
            $display("FAIL single_grant: got %b want %b", bus.master_granted, 3'b010);
        end
        vectors++;
        if (bus.slv_HADDR !== bus.mstHADDR[1] || bus.slv_HTRANS !== HTRANS_NONSEQ) begin
            errors++;
            $display("FAIL single_addr: got %h/%b want %h/%b", bus.slv_HADDR, bus.slv_HTRANS, bus.mstHADDR[1], HTRANS_NONSEQ);
        end
    endtask

    task automatic test_priority();
        do_reset();
        bus.mstHSEL[0] = 1'b1; bus.mstpriority[0] = 3'd1; bus.mstHTRANS[0] = HTRANS_NONSEQ;
        bus.mstHSEL[2] = 1'b1; bus.mstpriority[2] = 3'd5; bus.mstHTRANS[2] = HTRANS_NONSEQ;
        #1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (bus.master_granted !== 3'b100) begin
                errors++;
                $display("FAIL prio_hold%0d: got %b want %b", c, bus.master_granted, 3'b100);
            end
        end
        bus.mstHSEL[2] = 1'b0;
        #1;
        vectors++;
        if (bus.slv_HSEL !== 1'b0 || bus.slv_HTRANS !== HTRANS_IDLE) begin
            errors++;
            $display("FAIL prio_idle: got hsel %b htrans %b want 0 00", bus.slv_HSEL, bus.slv_HTRANS);
        end
        tick();
        vectors++;
        if (bus.master_granted !== 3'b001) begin
            errors++;
            $display("FAIL prio_drop: got %b want %b", bus.master_granted, 3'b001);
        end
    endtask

    task automatic test_round_robin();
        logic [M-1:0] seq [5];
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001; seq[4] = 3'b010;
        do_reset();
        for (int i = 0; i < M; i++) begin
            bus.mstHSEL[i] = 1'b1; bus.mstpriority[i] = 3'd3; bus.mstHTRANS[i] = HTRANS_NONSEQ;
        end
        #1;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (bus.master_granted !== seq[c]) begin
                errors++;
                $display("FAIL rr_step%0d: got %b want %b", c, bus.master_granted, seq[c]);
            end
        end
    endtask

    task automatic test_no_preempt();
        do_reset();
        bus.mstHSEL[0] = 1'b1; bus.mstHTRANS[0] = HTRANS_NONSEQ; bus.mstHBURST[0] = HBURST_INCR4;
        bus.can_switch[0] = 1'b0;
        bus.mstHSEL[1] = 1'b1; bus.mstpriority[1] = 3'd7; bus.mstHTRANS[1] = HTRANS_NONSEQ;
        #1;
        for (int c = 0; c < 4; c++) begin
            tick();
            bus.mstHTRANS[0] = HTRANS_SEQ;
            #1;
            vectors++;
            if (bus.master_granted !== 3'b001 || bus.slv_HBURST !== HBURST_INCR4) begin
                errors++;
                $display("FAIL nopreempt%0d: got %b/%b want 001/%b", c, bus.master_granted, bus.slv_HBURST, HBURST_INCR4);
            end
        end
        bus.can_switch[0] = 1'b1;
        #1;
        tick();
        vectors++;
        if (bus.master_granted !== 3'b010) begin
            errors++;
            $display("FAIL nopreempt_release: got %b want %b", bus.master_granted, 3'b010);
        end
    endtask

    task automatic test_lock();
        do_reset();
        bus.mstHSEL[0] = 1'b1; bus.mstHTRANS[0] = HTRANS_NONSEQ; bus.mstHMASTLOCK[0] = 1'b1;
        bus.mstHSEL[1] = 1'b1; bus.mstpriority[1] = 3'd7;
        #1;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (bus.master_granted !== 3'b001 || bus.slv_HMASTLOCK !== 1'b1) begin
                errors++;
                $display("FAIL lock_hold%0d: got %b/%b want 001/1", c, bus.master_granted, bus.slv_HMASTLOCK);
            end
        end
        bus.mstHMASTLOCK[0] = 1'b0;
        #1;
        tick();
        vectors++;
        if (bus.master_granted !== 3'b010) begin
            errors++;
            $display("FAIL lock_release: got %b want %b", bus.master_granted, 3'b010);
        end
    endtask

    task automatic test_wait_states();
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        do_reset();
        d0 = 32'hA5A5_0000 | 32'($urandom_range(0, 65535));
        d1 = ~d0;
        bus.mstHSEL[0] = 1'b1; bus.mstHWRITE[0] = 1'b1; bus.mstHTRANS[0] = HTRANS_NONSEQ;
        bus.mstpriority[0] = 3'd1; bus.mstHWDATA[0] = d0;
        bus.mstHSEL[1] = 1'b1; bus.mstpriority[1] = 3'd6; bus.mstHTRANS[1] = HTRANS_NONSEQ;
        bus.mstHWDATA[1] = d1;
        #1;
        tick();
        bus.slv_HREADY = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if (bus.master_granted !== 3'b010 || bus.slv_HWDATA !== d0) begin
                errors++;
                $display("FAIL wait%0d: got %b/%h want 010/%h", c, bus.master_granted, bus.slv_HWDATA, d0);
            end
            tick();
        end
        bus.slv_HREADY = 1'b1;
        #1;
        vectors++;
        if (bus.slv_HWDATA !== d0) begin
            errors++;
            $display("FAIL wait_last: got %h want %h", bus.slv_HWDATA, d0);
        end
        tick();
        vectors++;
        if (bus.slv_HWDATA !== d1) begin
            errors++;
            $display("FAIL wait_handover: got %h want %h", bus.slv_HWDATA, d1);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < M; i++) begin
                bus.mstpriority[i]  = 3'($urandom_range(0, 7));
                bus.mstHSEL[i]      = ($urandom_range(0, 3) != 0);
                bus.mstHADDR[i]     = $urandom;
                bus.mstHWDATA[i]    = $urandom;
                bus.mstHWRITE[i]    = 1'($urandom);
                bus.mstHSIZE[i]     = 3'($urandom);
                bus.mstHBURST[i]    = 3'($urandom);
                bus.mstHPROT[i]     = 4'($urandom);
                bus.mstHTRANS[i]    = 2'($urandom);
                bus.mstHMASTLOCK[i] = ($urandom_range(0, 7) == 0);
                bus.mstHREADY[i]    = 1'($urandom);
                bus.can_switch[i]   = ($urandom_range(0, 3) != 0);
            end
            bus.slv_HRDATA = $urandom;
            bus.slv_HREADY = ($urandom_range(0, 3) != 0);
            bus.slv_HRESP  = 1'($urandom);
            #1;
            vectors++;
            if (bus.master_granted !== M'(1 << m_owner)) begin
                errors++;
                $display("FAIL rnd_grant c%0d: got %b want %b", c, bus.master_granted, M'(1 << m_owner));
            end
            vectors++;
            if (bus.slv_HADDR !== bus.mstHADDR[m_owner] || bus.slv_HWRITE !== bus.mstHWRITE[m_owner] ||
                bus.slv_HSIZE !== bus.mstHSIZE[m_owner] || bus.slv_HBURST !== bus.mstHBURST[m_owner] ||
                bus.slv_HPROT !== bus.mstHPROT[m_owner] || bus.slv_HMASTLOCK !== bus.mstHMASTLOCK[m_owner]) begin
                errors++;
                $display("FAIL rnd_addrphase c%0d: got addr %h want %h (owner %0d)", c, bus.slv_HADDR, bus.mstHADDR[m_owner], m_owner);
            end
            vectors++;
            if (bus.slv_HSEL !== bus.mstHSEL[m_owner] ||
                bus.slv_HTRANS !== (bus.mstHSEL[m_owner] ? bus.mstHTRANS[m_owner] : HTRANS_IDLE)) begin
                errors++;
                $display("FAIL rnd_htrans c%0d: got %b/%b want sel %b trans %b", c, bus.slv_HSEL, bus.slv_HTRANS, bus.mstHSEL[m_owner], bus.mstHTRANS[m_owner]);
            end
            vectors++;
            if (bus.slv_HWDATA !== bus.mstHWDATA[m_downer]) begin
                errors++;
                $display("FAIL rnd_hwdata c%0d: got %h want %h", c, bus.slv_HWDATA, bus.mstHWDATA[m_downer]);
            end
            vectors++;
            if (bus.slv_HREADYOUT !== bus.mstHREADY[m_owner]) begin
                errors++;
                $display("FAIL rnd_hreadyout c%0d: got %b want %b", c, bus.slv_HREADYOUT, bus.mstHREADY[m_owner]);
            end
            vectors++;
            if (bus.mstHRDATA !== bus.slv_HRDATA || bus.mstHREADYOUT !== bus.slv_HREADY || bus.mstHRESP !== bus.slv_HRESP) begin
                errors++;
                $display("FAIL rnd_resp c%0d: got %h/%b/%b want %h/%b/%b", c, bus.mstHRDATA, bus.mstHREADYOUT, bus.mstHRESP, bus.slv_HRDATA, bus.slv_HREADY, bus.slv_HRESP);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.mstHSEL[2] = 1'b1; bus.mstpriority[2] = 3'd4; bus.mstHTRANS[2] = HTRANS_NONSEQ;
        bus.mstHWRITE[2] = 1'b1;
        #1;
        tick();
        tick();
        vectors++;
        if (bus.master_granted !== 3'b100 || bus.slv_HWDATA !== bus.mstHWDATA[2]) begin
            errors++;
            $display("FAIL midrst_setup: got %b/%h want 100/%h", bus.master_granted, bus.slv_HWDATA, bus.mstHWDATA[2]);
        end
        #2;
        HRESETn = 1'b0;
        #1;
        vectors++;
        if (bus.master_granted !== 3'b001 || bus.slv_HADDR !== bus.mstHADDR[0] || bus.slv_HWDATA !== bus.mstHWDATA[0]) begin
            errors++;
            $display("FAIL midrst_async: got %b/%h/%h want 001/%h/%h", bus.master_granted, bus.slv_HADDR, bus.slv_HWDATA, bus.mstHADDR[0], bus.mstHWDATA[0]);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_priority();
        test_round_robin();
        test_no_preempt();
        test_lock();
        test_wait_states();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
